// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/execute sequencer: owns the PC, fetches over req/ack, gates the register write strobe.
// Optional single-step control is enabled by defining SEQ_SINGLE_STEP_EN (adds the step input).
module instr_sequencer #(
    parameter int                     PC_WIDTH    = 12,
    parameter int                     INSTR_WIDTH = 16,
    parameter logic [INSTR_WIDTH-1:0] HALT_INSTR  = 16'hFFFF,
    parameter int                     FETCH_TMO   = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                   step,
`endif
    output logic                   mem_req,
    output logic [PC_WIDTH-1:0]    mem_addr,
    input  logic                   mem_ack,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    output logic [INSTR_WIDTH-1:0] instr,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    input  logic                   reg_we_in,
    output logic                   reg_we,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [15:0]            retired,
    output logic                   halted,
    output logic                   fault
);
    // Memory handshake: mem_req is high for every FETCH cycle and mem_addr is held at pc;
    // a fetch completes on the first cycle that both mem_req and mem_ack are high.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        WB    = 3'd3,
        HALT  = 3'd4,
        FAULT = 3'd5
    } state_t;

    localparam int TMO_W = (FETCH_TMO > 1) ? $clog2(FETCH_TMO) : 1;
    localparam bit TMO_EN = (FETCH_TMO != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((FETCH_TMO > 0) ? FETCH_TMO - 1 : 0);

    state_t            state;
    state_t            state_nxt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              br_q;
    logic [PC_WIDTH-1:0] tgt_q;
    logic              we_q;
    logic              go;

`ifdef SEQ_SINGLE_STEP_EN
    assign go = run & step;
`else
    assign go = run;
`endif

    assign mem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        reg_we    = 1'b0;
        halted    = 1'b0;
        fault     = 1'b0;
        case (state)
            IDLE: begin
                if (go) state_nxt = FETCH;
            end
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_nxt = EXEC;
                end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
                    state_nxt = FAULT;
                end
            end
            EXEC: begin
                state_nxt = (instr == HALT_INSTR) ? HALT : WB;
            end
            WB: begin
                reg_we    = we_q;
                state_nxt = go ? FETCH : IDLE;
            end
            HALT:    halted = 1'b1;
            FAULT:   fault  = 1'b1;
            default: state_nxt = IDLE;
        endcase
    end

    // Control-unit outputs are captured in EXEC so WB acts on a stable snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= '0;
            instr   <= '0;
            retired <= '0;
            tmo_cnt <= '0;
            br_q    <= 1'b0;
            tgt_q   <= '0;
            we_q    <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ack) begin
                        instr   <= mem_rdata;
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                EXEC: begin
                    if (instr != HALT_INSTR) begin
                        br_q  <= branch_taken;
                        tgt_q <= branch_target;
                        we_q  <= reg_we_in;
                    end
                end
                WB: begin
                    pc      <= br_q ? tgt_q : pc + 1'b1;
                    retired <= retired + 16'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed-plus-random bench for instr_sequencer; a transaction-level model tracks pc and retire count.
module tb_instr_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0;
    logic [15:0] instr;
    logic        branch_taken = 1'b0;
    logic [11:0] branch_target = 12'h0;
    logic        reg_we_in = 1'b0;
    logic        reg_we;
    logic [11:0] pc;
    logic [15:0] retired;
    logic        halted;
    logic        fault;
`ifdef SEQ_SINGLE_STEP_EN
    logic        step = 1'b1;
`endif

    int n_pass = 0;
    int n_total = 0;

    // Reference model state: one update per retired instruction.
    logic [11:0] m_pc = 12'h0;
    logic [15:0] m_retired = 16'h0;
    logic [15:0] m_instr = 16'h0;

    instr_sequencer #(.FETCH_TMO(4)) dut (
        .clk(clk),
        .reset(reset),
        .run(run),
`ifdef SEQ_SINGLE_STEP_EN
        .step(step),
`endif
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .instr(instr),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .reg_we_in(reg_we_in),
        .reg_we(reg_we),
        .pc(pc),
        .retired(retired),
        .halted(halted),
        .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_reset_vals();
        m_pc = 12'h0;
        m_retired = 16'h0;
        m_instr = 16'h0;
        chk("rst_pc", 32'(pc), 32'(m_pc));
        chk("rst_instr", 32'(instr), 32'(m_instr));
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(reg_we), 32'd0);
        chk("rst_retired", 32'(retired), 32'(m_retired));
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        w = 16'($urandom);
        if (w == 16'hFFFF) w = 16'h0;
        return w;
    endfunction

    // Precondition: DUT is in its first FETCH cycle. Leaves it in the next FETCH cycle.
    task automatic do_instr(input int waits, input logic [15:0] word, input logic br,
                            input logic [11:0] tgt, input logic we, input logic drop);
        for (int w = 0; w < waits; w++) begin
            chk("fetch_req", 32'(mem_req), 32'd1);
            chk("fetch_addr", 32'(mem_addr), 32'(m_pc));
            chk("fetch_we", 32'(reg_we), 32'd0);
            mem_ack = 1'b0;
            mem_rdata = 16'($urandom);
            tick();
        end
        chk("fetch_req", 32'(mem_req), 32'd1);
        chk("fetch_addr", 32'(mem_addr), 32'(m_pc));
        mem_ack = 1'b1;
        mem_rdata = word;
        tick();
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = 16'($urandom);
        chk("exec_req", 32'(mem_req), 32'd0);
        chk("exec_instr", 32'(instr), 32'(word));
        chk("exec_we", 32'(reg_we), 32'd0);
        branch_taken = br;
        branch_target = tgt;
        reg_we_in = we;
        if (drop) run = 1'b0;
        tick();
        branch_taken = ~br;
        branch_target = ~tgt;
        reg_we_in = ~we;
        chk("wb_we", 32'(reg_we), 32'(we));
        chk("wb_req", 32'(mem_req), 32'd0);
        chk("wb_instr", 32'(instr), 32'(word));
        tick();
        mem_ack = 1'b0;
        m_instr = word;
        m_pc = br ? tgt : m_pc + 12'd1;
        m_retired = m_retired + 16'd1;
        chk("pc", 32'(pc), 32'(m_pc));
        chk("retired", 32'(retired), 32'(m_retired));
        chk("post_wb_we", 32'(reg_we), 32'd0);
        if (drop) begin
            for (int i = 0; i < 3; i++) begin
                chk("idle_req", 32'(mem_req), 32'd0);
                chk("idle_we", 32'(reg_we), 32'd0);
                mem_ack = 1'b1;
                mem_rdata = 16'hFFFF;
                tick();
            end
            mem_ack = 1'b0;
            chk("idle_instr", 32'(instr), 32'(m_instr));
            chk("idle_halted", 32'(halted), 32'd0);
            run = 1'b1;
            tick();
        end
    endtask

    initial begin
        // Reset and idle
        reset = 1'b1;
        run = 1'b0;
        repeat (3) tick();
        check_reset_vals();
        reset = 1'b0;
        tick();
        tick();
        chk("idle_norun_req", 32'(mem_req), 32'd0);
        run = 1'b1;
        tick();

        // Back-to-back fetches at addresses 0,1,2 with no wait states
        do_instr(0, 16'h1230, 1'b0, 12'h0, 1'b1, 1'b0);
        do_instr(0, 16'h4561, 1'b0, 12'h0, 1'b1, 1'b0);
        do_instr(0, 16'h7892, 1'b0, 12'h0, 1'b1, 1'b0);
        chk("retired_after_3", 32'(retired), 32'd3);

        // Reach pc=5, then branch to 0x0A0
        do_instr(1, rand_word(), 1'b0, 12'h0, 1'b0, 1'b0);
        do_instr(2, rand_word(), 1'b0, 12'h0, 1'b1, 1'b0);
        chk("pc_is_5", 32'(pc), 32'h5);
        do_instr(0, rand_word(), 1'b1, 12'h0A0, 1'b1, 1'b0);
        chk("branch_addr", 32'(mem_addr), 32'h0A0);

        // PC wrap from 0xFFF to 0x000
        do_instr(1, rand_word(), 1'b1, 12'hFFF, 1'b0, 1'b0);
        do_instr(0, rand_word(), 1'b0, 12'h0, 1'b1, 1'b0);
        chk("wrap_addr", 32'(mem_addr), 32'h000);

        // Run dropped during EXEC
        do_instr(0, rand_word(), 1'b0, 12'h0, 1'b1, 1'b1);

        // Randomized instruction stream
        for (int i = 0; i < 30; i++) begin
            do_instr($urandom_range(0, 3), rand_word(), ($urandom_range(0, 3) == 0),
                     12'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0));
        end

        // HALT: the halt word does not retire, write, or move pc
        mem_ack = 1'b1;
        mem_rdata = 16'hFFFF;
        tick();
        mem_ack = 1'b0;
        chk("halt_exec_halted", 32'(halted), 32'd0);
        chk("halt_exec_instr", 32'(instr), 32'hFFFF);
        branch_taken = 1'b1;
        branch_target = 12'h123;
        reg_we_in = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("halt_halted", 32'(halted), 32'd1);
            chk("halt_req", 32'(mem_req), 32'd0);
            chk("halt_we", 32'(reg_we), 32'd0);
            chk("halt_pc", 32'(pc), 32'(m_pc));
            chk("halt_retired", 32'(retired), 32'(m_retired));
            mem_ack = 1'($urandom);
            tick();
        end
        mem_ack = 1'b0;
        reset = 1'b1;
        tick();
        check_reset_vals();
        reset = 1'b0;
        tick();

        // Reset in the middle of a FETCH
        do_instr(0, 16'h2222, 1'b0, 12'h0, 1'b0, 1'b0);
        mem_ack = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check_reset_vals();
        reset = 1'b0;
        tick();
        do_instr(1, 16'h3456, 1'b0, 12'h0, 1'b1, 1'b0);

        // Fetch time-out after 4 FETCH cycles, late ack ignored
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("tmo_fault_low", 32'(fault), 32'd0);
            chk("tmo_req", 32'(mem_req), 32'd1);
            tick();
        end
        chk("tmo_fault", 32'(fault), 32'd1);
        chk("tmo_req_off", 32'(mem_req), 32'd0);
        mem_ack = 1'b1;
        mem_rdata = 16'h3333;
        repeat (3) tick();
        chk("late_ack_fault", 32'(fault), 32'd1);
        chk("late_ack_req", 32'(mem_req), 32'd0);
        chk("late_ack_instr", 32'(instr), 32'(m_instr));
        chk("late_ack_pc", 32'(pc), 32'(m_pc));
        chk("late_ack_we", 32'(reg_we), 32'd0);
        mem_ack = 1'b0;
        run = 1'b0;
        reset = 1'b1;
        tick();
        check_reset_vals();
        reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
